// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared constants, FSM encodings and helpers for the RAM port arbiter
package ram_arb_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DATA_W  = 4;
  localparam int GRANT_CNT_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RDATA  = 2'd2;

  // Index width for a requester number; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// rtl/ram_port_arbiter_rr_pick.sv - combinational round-robin winner search starting after last_grant
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_req_o
);

  logic [IDX_W-1:0] cand;

  // Scan farthest-first so the nearest requester after last_grant overwrites the result.
  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant_i) + k) % NUM_REQ);
      if (req_i[cand]) begin
        winner_o  = cand;
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin sharing of one single-port sync RAM; RAM_ARB_GRANT_CNT_EN adds grant counters
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
`ifdef RAM_ARB_GRANT_CNT_EN
  output logic [NUM_REQ*GRANT_CNT_W-1:0] grant_cnt,
`endif
  output logic                      ram_cs,
  output logic                      ram_wr_rd,
  output logic [ADDR_W-1:0]         ram_address,
  output logic [DATA_W-1:0]         ram_data_in,
  input  logic [DATA_W-1:0]         ram_data_out
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic               ram_cs_q, ram_cs_d;
  logic               ram_wr_rd_q, ram_wr_rd_d;
  logic [ADDR_W-1:0]  ram_address_q, ram_address_d;
  logic [DATA_W-1:0]  ram_data_in_q, ram_data_in_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [IDX_W-1:0]   winner;
  logic               any_req;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .winner_o     (winner),
    .any_req_o    (any_req)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    ram_cs_d      = 1'b0;
    ram_wr_rd_d   = ram_wr_rd_q;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    rsp_valid_d   = '0;
    rsp_rdata_d   = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d       = winner;
          last_grant_d  = winner;
          ram_cs_d      = 1'b1;
          ram_wr_rd_d   = req_we[winner];
          ram_address_d = req_addr[int'(winner)*ADDR_W +: ADDR_W];
          ram_data_in_d = req_we[winner] ? req_wdata[int'(winner)*DATA_W +: DATA_W] : '0;
          state_d       = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ram_wr_rd_q ? ST_IDLE : ST_RDATA;
      ST_RDATA: begin
        rsp_rdata_d          = ram_data_out;
        rsp_valid_d[grant_q] = 1'b1;
        state_d              = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
      ram_cs_q      <= 1'b0;
      ram_wr_rd_q   <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      ram_cs_q      <= ram_cs_d;
      ram_wr_rd_q   <= ram_wr_rd_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  // Accept pulse is decoded from flops so it lines up exactly with ram_cs.
  assign req_ready   = (state_q == ST_ACCESS) ? (NUM_REQ'(1) << grant_q) : '0;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign ram_cs      = ram_cs_q;
  assign ram_wr_rd   = ram_wr_rd_q;
  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;

`ifdef RAM_ARB_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (state_q == ST_ACCESS && cnt_q[grant_q] != '1) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_out
    assign grant_cnt[gi*GRANT_CNT_W +: GRANT_CNT_W] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter with a 16x4 registered-read RAM model
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_we = '0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [3:0] rsp_rdata;
  logic       ram_cs;
  logic       ram_wr_rd;
  logic [3:0] ram_address;
  logic [3:0] ram_data_in;
  logic [3:0] ram_data_out = '0;
`ifdef RAM_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         req;
    logic [3:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         grant_log[$];
  logic [3:0] mem [16];
  logic [3:0] model [16];

  ram_port_arbiter #(.NUM_REQ(2), .ADDR_W(4), .DATA_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
`ifdef RAM_ARB_GRANT_CNT_EN
    .grant_cnt    (grant_cnt),
`endif
    .ram_cs       (ram_cs),
    .ram_wr_rd    (ram_wr_rd),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 16x4 single-port RAM with registered read; untouched by the arbiter reset.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_wr_rd) mem[ram_address] <= ram_data_in;
      else ram_data_out <= mem[ram_address];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (ram_cs !== (req_ready != 2'b00) || $countones(req_ready) > 1) begin
        failures++;
        $display("FAIL cs_ready_overlap cyc=%0d ram_cs=%b req_ready=%b", cyc, ram_cs, req_ready);
      end
      if (req_ready == 2'b01) grant_log.push_back(0);
      if (req_ready == 2'b10) grant_log.push_back(1);
      if (rsp_valid != 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rsp cyc=%0d rsp_valid=%b want=00", cyc, rsp_valid);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (rsp_valid !== 2'(1 << e.req) || rsp_rdata !== e.data || cyc != e.cyc) begin
            failures++;
            $display("FAIL rsp_data cyc=%0d got valid=%b data=%h want valid=%b data=%h cyc=%0d",
                     cyc, rsp_valid, rsp_rdata, 2'(1 << e.req), e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_op(input int i, input bit we, input logic [3:0] addr,
                       input logic [3:0] data, input bit expect_rsp);
    int n;
    logic [3:0] want_din;
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*4 +: 4] = addr;
    req_wdata[i*4 +: 4] = data;
    want_din = we ? data : 4'h0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!req_ready[i] && n < 100);
    req_valid[i] = 1'b0;
    checks++;
    if (!req_ready[i]) begin
      failures++;
      $display("FAIL ready_timeout req=%0d got=0 want=1", i);
    end else begin
      checks++;
      if ({ram_cs, ram_wr_rd, ram_address, ram_data_in} !== {1'b1, we, addr, want_din}) begin
        failures++;
        $display("FAIL access_pins req=%0d got cs=%b wr=%b a=%h d=%h want cs=1 wr=%b a=%h d=%h",
                 i, ram_cs, ram_wr_rd, ram_address, ram_data_in, we, addr, want_din);
      end
      if (we) model[addr] = data;
      else if (expect_rsp) exp_q.push_back('{i, model[addr], cyc + 2});
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({ram_cs, ram_wr_rd, ram_address, ram_data_in, rsp_valid, rsp_rdata, req_ready} !== 20'h0) begin
      failures++;
      $display("FAIL %s got cs=%b wr=%b a=%h d=%h rv=%b rd=%h rdy=%b want all 0",
               tag, ram_cs, ram_wr_rd, ram_address, ram_data_in, rsp_valid, rsp_rdata, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 check_idle_outputs("reset_outputs");
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1 check_idle_outputs("idle_outputs");
    end
  endtask

  task automatic test_write_read();
    do_op(0, 1'b1, 4'h3, 4'hA, 1'b0);
    do_op(0, 1'b0, 4'h3, 4'h0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_contention();
    mem[1] = 4'h5; model[1] = 4'h5;
    mem[2] = 4'h6; model[2] = 4'h6;
    apply_reset();
    grant_log.delete();
    fork
      do_op(0, 1'b0, 4'h1, 4'h0, 1'b1);
      do_op(1, 1'b0, 4'h2, 4'h0, 1'b1);
    join
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
      failures++;
      $display("FAIL contention_order got size=%0d want grants 0,1", grant_log.size());
    end
  endtask

  task automatic test_fairness();
    int cnt0, cnt1, bad;
    apply_reset();
    grant_log.delete();
    fork
      for (int k = 0; k < 8; k++) do_op(0, 1'b1, 4'(k), 4'(k), 1'b0);
      for (int k = 0; k < 8; k++) do_op(1, 1'b1, 4'(8 + k), ~4'(k), 1'b0);
    join
    repeat (2) @(posedge clk);
    #1;
    cnt0 = 0; cnt1 = 0; bad = 0;
    foreach (grant_log[j]) begin
      if (grant_log[j] == 0) cnt0++; else cnt1++;
      if (grant_log[j] != (j % 2)) bad++;
    end
    checks++;
    if (cnt0 != 8 || cnt1 != 8 || bad != 0) begin
      failures++;
      $display("FAIL fairness got cnt0=%0d cnt1=%0d out_of_order=%0d want 8 8 0", cnt0, cnt1, bad);
    end
  endtask

  task automatic test_reset_in_rdata();
    do_op(0, 1'b1, 4'hF, 4'h9, 1'b0);
    do_op(1, 1'b0, 4'hF, 4'h0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1 check_idle_outputs("reset_rdata_outputs");
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 2'b00) begin
        failures++;
        $display("FAIL discarded_read got rsp_valid=%b want=00", rsp_valid);
      end
    end
    do_op(0, 1'b0, 4'hF, 4'h0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

`ifdef RAM_ARB_GRANT_CNT_EN
  task automatic test_grant_cnt();
    apply_reset();
    for (int k = 0; k < 300; k++) do_op(0, 1'b1, 4'(k), 4'(k >> 4), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (grant_cnt !== 16'h00FF) begin
      failures++;
      $display("FAIL grant_cnt_saturate got=%h want=00ff", grant_cnt);
    end
  endtask
`endif

  initial begin
    foreach (mem[j]) begin
      mem[j] = '0;
      model[j] = '0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_contention();
    test_fairness();
    test_reset_in_rdata();
`ifdef RAM_ARB_GRANT_CNT_EN
    test_grant_cnt();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_rsp got outstanding=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
